cart_rom_mapper: RTL and testbench

//  Cartridge bank-switch stage downstream of ROM type detection. Latches the detected

---
 rtl/cart_rom_mapper.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cart_rom_mapper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_mapper.sv
// Cartridge bank-switch stage: latches the detected mapper at ROM load time,
// tracks bank writes from the Z80 and produces registered ROM/SRAM addresses.
module cart_rom_mapper #(
  parameter int BANK_W  = 8,
  parameter int SRAM_AW = 13
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  input  logic [2:0]          mapper,
  input  logic [3:0]          offset,
  input  logic [24:0]         rom_size,
  input  logic                slot_sel,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_dout,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  output logic [24:0]         rom_addr,
  output logic                rom_oe,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic                sram_oe,
  output logic                sram_we,
  output logic                scc_sel,
  output logic [2:0]          cfg_mapper
);

  localparam logic [2:0] M_UNKNOWN = 3'd0;
  localparam logic [2:0] M_NONE    = 3'd1;
  localparam logic [2:0] M_GM2     = 3'd2;
  localparam logic [2:0] M_KONAMI  = 3'd3;
  localparam logic [2:0] M_SCC     = 3'd4;
  localparam logic [2:0] M_ASCII8  = 3'd5;
  localparam logic [2:0] M_ASCII16 = 3'd6;

  // Power-of-two size minus one, never below 8 KB.
  function automatic logic [24:0] size_mask(input logic [24:0] sz);
    logic [24:0] m;
    m = sz - 25'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m | 25'h1FFF;
  endfunction

  function automatic logic [BANK_W-1:0] bank_default(input logic [2:0] m, input logic [1:0] idx);
    logic [BANK_W-1:0] b;
    case (m)
      M_ASCII8, M_ASCII16: b = '0;
      default:             b = BANK_W'(idx);
    endcase
    return b;
  endfunction

  logic [2:0]         cfg_mapper_r;
  logic [3:0]         offset_r;
  logic [24:0]        rom_size_r;
  logic [24:0]        size_mask_r;
  logic [BANK_W-1:0]  bank_r [4];

  logic               wr_en_s;
  logic [1:0]         wr_idx_s;
  logic               sram_wr_s;

  logic [24:0]        rom_addr_r, rom_addr_s;
  logic               rom_oe_r, rom_oe_s;
  logic [SRAM_AW-1:0] sram_addr_r, sram_addr_s;
  logic               sram_oe_r, sram_oe_s;
  logic               sram_we_r;
  logic               scc_sel_r, scc_sel_s;

  logic [1:0]         region_s;
  logic               in_win_s;
  logic [BANK_W-1:0]  bank_sel_s;
  logic [BANK_W-1:0]  bmask_s;
  logic [BANK_W-1:0]  b16_s;
  logic [15:0]        base_s;
  logic [24:0]        span_s;
  logic               lin_hit_s;
  logic [24:0]        lin_addr_s;

  // Configuration latch on ROM load completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_mapper_r <= 3'd0;
      offset_r     <= 4'd0;
      rom_size_r   <= 25'd0;
      size_mask_r  <= 25'd0;
    end else if (cfg_valid) begin
      cfg_mapper_r <= mapper;
      offset_r     <= offset;
      rom_size_r   <= rom_size;
      size_mask_r  <= size_mask(rom_size);
    end
  end

  // Bank register write decode; a same-cycle cfg_valid drops the write.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = 2'd0;
    sram_wr_s = 1'b0;
    if (cpu_wr && slot_sel && !cfg_valid) begin
      case (cfg_mapper_r)
        M_KONAMI: begin
          case (cpu_addr[15:13])
            3'b011:  begin wr_en_s = 1'b1; wr_idx_s = 2'd1; end
            3'b100:  begin wr_en_s = 1'b1; wr_idx_s = 2'd2; end
            3'b101:  begin wr_en_s = 1'b1; wr_idx_s = 2'd3; end
            default: wr_en_s = 1'b0;
          endcase
        end
        M_SCC: begin
          case (cpu_addr[15:11])
            5'b01010: begin wr_en_s = 1'b1; wr_idx_s = 2'd0; end
            5'b01110: begin wr_en_s = 1'b1; wr_idx_s = 2'd1; end
            5'b10010: begin wr_en_s = 1'b1; wr_idx_s = 2'd2; end
            5'b10110: begin wr_en_s = 1'b1; wr_idx_s = 2'd3; end
            default:  wr_en_s = 1'b0;
          endcase
        end
        M_ASCII8: begin
          if (cpu_addr[15:13] == 3'b011) begin
            wr_en_s  = 1'b1;
            wr_idx_s = cpu_addr[12:11];
          end else begin
            wr_en_s = 1'b0;
          end
        end
        M_ASCII16: begin
          case (cpu_addr[15:11])
            5'b01100: begin wr_en_s = 1'b1; wr_idx_s = 2'd0; end
            5'b01110: begin wr_en_s = 1'b1; wr_idx_s = 2'd1; end
            default:  wr_en_s = 1'b0;
          endcase
        end
        M_GM2: begin
          case (cpu_addr[15:12])
            4'h6:    begin wr_en_s = 1'b1; wr_idx_s = 2'd1; end
            4'h8:    begin wr_en_s = 1'b1; wr_idx_s = 2'd2; end
            4'hA:    begin wr_en_s = 1'b1; wr_idx_s = 2'd3; end
            4'hB: begin
              if (bank_r[3][4]) begin
                sram_wr_s = 1'b1;
              end else begin
                sram_wr_s = 1'b0;
              end
            end
            default: wr_en_s = 1'b0;
          endcase
        end
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Bank registers, reloaded with per-mapper defaults on every new configuration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) bank_r[i] <= bank_default(3'd0, 2'(i));
    end else if (cfg_valid) begin
      for (int i = 0; i < 4; i++) bank_r[i] <= bank_default(mapper, 2'(i));
    end else if (wr_en_s) begin
      bank_r[wr_idx_s] <= BANK_W'(cpu_dout);
    end
  end

  assign region_s   = cpu_addr[14:13] ^ 2'b10;
  assign in_win_s   = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);
  assign bank_sel_s = bank_r[region_s];
  assign bmask_s    = size_mask_r[BANK_W+12:13];
  assign b16_s      = bank_r[{1'b0, cpu_addr[15]}];
  assign base_s     = {offset_r, 12'h000};
  assign span_s     = (rom_size_r <= 25'h4000) ? 25'h4000 : rom_size_r;
  // 26-bit compare keeps base+span from wrapping.
  assign lin_hit_s  = (rom_size_r != 25'd0) && (cpu_addr >= base_s) &&
                      ({10'd0, cpu_addr} < ({10'd0, base_s} + {1'b0, span_s}));
  assign lin_addr_s = {9'd0, cpu_addr - base_s} & size_mask_r;

  // Read decode for the current access.
  always_comb begin
    rom_addr_s  = 25'd0;
    rom_oe_s    = 1'b0;
    sram_addr_s = '0;
    sram_oe_s   = 1'b0;
    scc_sel_s   = 1'b0;
    if (cpu_rd && slot_sel) begin
      case (cfg_mapper_r)
        M_UNKNOWN, M_NONE: begin
          if (lin_hit_s) begin
            rom_oe_s   = 1'b1;
            rom_addr_s = lin_addr_s;
          end else begin
            rom_oe_s = 1'b0;
          end
        end
        M_KONAMI, M_ASCII8: begin
          if (in_win_s) begin
            rom_oe_s   = 1'b1;
            rom_addr_s = 25'({bank_sel_s & bmask_s, cpu_addr[12:0]});
          end else begin
            rom_oe_s = 1'b0;
          end
        end
        M_SCC: begin
          if (in_win_s && (bank_r[2][5:0] == 6'h3F) && (cpu_addr[15:11] == 5'b10011)) begin
            scc_sel_s = 1'b1;
          end else if (in_win_s) begin
            rom_oe_s   = 1'b1;
            rom_addr_s = 25'({bank_sel_s & bmask_s, cpu_addr[12:0]});
          end else begin
            rom_oe_s = 1'b0;
          end
        end
        M_ASCII16: begin
          if (in_win_s) begin
            rom_oe_s   = 1'b1;
            rom_addr_s = 25'({b16_s & {1'b0, bmask_s[BANK_W-1:1]}, cpu_addr[13:0]});
          end else begin
            rom_oe_s = 1'b0;
          end
        end
        M_GM2: begin
          if (in_win_s && bank_sel_s[4]) begin
            sram_oe_s   = 1'b1;
            sram_addr_s = SRAM_AW'({bank_sel_s[5], cpu_addr[11:0]});
          end else if (in_win_s) begin
            rom_oe_s   = 1'b1;
            rom_addr_s = 25'({bank_sel_s & bmask_s, cpu_addr[12:0]});
          end else begin
            rom_oe_s = 1'b0;
          end
        end
        default: rom_oe_s = 1'b0;
      endcase
    end else begin
      rom_oe_s = 1'b0;
    end
    if (sram_wr_s) begin
      sram_addr_s = SRAM_AW'({bank_r[3][5], cpu_addr[11:0]});
    end else begin
      sram_addr_s = sram_addr_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_r  <= 25'd0;
      rom_oe_r    <= 1'b0;
      sram_addr_r <= '0;
      sram_oe_r   <= 1'b0;
      sram_we_r   <= 1'b0;
      scc_sel_r   <= 1'b0;
    end else begin
      rom_addr_r  <= rom_addr_s;
      rom_oe_r    <= rom_oe_s;
      sram_addr_r <= sram_addr_s;
      sram_oe_r   <= sram_oe_s;
      sram_we_r   <= sram_wr_s;
      scc_sel_r   <= scc_sel_s;
    end
  end

  assign rom_addr   = rom_addr_r;
  assign rom_oe     = rom_oe_r;
  assign sram_addr  = sram_addr_r;
  assign sram_oe    = sram_oe_r;
  assign sram_we    = sram_we_r;
  assign scc_sel    = scc_sel_r;
  assign cfg_mapper = cfg_mapper_r;

endmodule

// File: tb/tb_cart_rom_mapper.sv
// Scenario bench for cart_rom_mapper: each beat's expected outputs are queued
// when driven and popped once the registered outputs are available.
module tb_cart_rom_mapper;

  typedef struct packed {
    logic [24:0] ra;
    logic        roe;
    logic [12:0] sa;
    logic        soe;
    logic        swe;
    logic        scc;
  } out_t;

  typedef struct packed {
    logic        cv;
    logic        sl;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  m;
    logic [3:0]  off;
    logic [24:0] sz;
    out_t        e;
  } stim_t;

  localparam out_t E_NONE = '0;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic [2:0]  mapper;
  logic [3:0]  offset;
  logic [24:0] rom_size;
  logic        slot_sel;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [24:0] rom_addr;
  logic        rom_oe;
  logic [12:0] sram_addr;
  logic        sram_oe;
  logic        sram_we;
  logic        scc_sel;
  logic [2:0]  cfg_mapper;

  int   total;
  int   bad;
  out_t exp_q[$];

  cart_rom_mapper #(.BANK_W(8), .SRAM_AW(13)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .mapper(mapper),
    .offset(offset), .rom_size(rom_size), .slot_sel(slot_sel), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .rom_addr(rom_addr),
    .rom_oe(rom_oe), .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_we(sram_we),
    .scc_sel(scc_sel), .cfg_mapper(cfg_mapper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t e_rom(input logic [24:0] ra);
    out_t o = E_NONE; o.ra = ra; o.roe = 1'b1; return o;
  endfunction
  function automatic out_t e_sram(input logic [12:0] sa);
    out_t o = E_NONE; o.sa = sa; o.soe = 1'b1; return o;
  endfunction
  function automatic out_t e_swe(input logic [12:0] sa);
    out_t o = E_NONE; o.sa = sa; o.swe = 1'b1; return o;
  endfunction
  function automatic out_t e_scc();
    out_t o = E_NONE; o.scc = 1'b1; return o;
  endfunction

  function automatic stim_t s_mk(input logic cv, sl, rd, wr, input logic [15:0] a,
                                 input logic [7:0] d, input out_t e);
    stim_t s = '0;
    s.cv = cv; s.sl = sl; s.rd = rd; s.wr = wr; s.a = a; s.d = d; s.e = e;
    return s;
  endfunction
  function automatic stim_t s_rd(input logic [15:0] a, input out_t e);
    return s_mk(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00, e);
  endfunction
  function automatic stim_t s_wr(input logic [15:0] a, input logic [7:0] d);
    return s_mk(1'b0, 1'b1, 1'b0, 1'b1, a, d, E_NONE);
  endfunction
  function automatic stim_t s_cf(input logic [2:0] m, input logic [3:0] off, input logic [24:0] sz);
    stim_t s = s_mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, E_NONE);
    s.m = m; s.off = off; s.sz = sz;
    return s;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then pop it against the outputs.
  task automatic beat(input stim_t s, output out_t o, output out_t x);
    cfg_valid = s.cv; slot_sel = s.sl; cpu_rd = s.rd; cpu_wr = s.wr;
    cpu_addr = s.a; cpu_dout = s.d; mapper = s.m; offset = s.off; rom_size = s.sz;
    exp_q.push_back(s.e);
    @(posedge clk);
    #1;
    o = {rom_addr, rom_oe, sram_addr, sram_oe, sram_we, scc_sel};
    x = exp_q.pop_front();
  endtask

  task automatic test_reset();
    stim_t s;
    out_t  o, x;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rom_addr, rom_oe, sram_addr, sram_oe, sram_we, scc_sel} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {rom_addr, rom_oe, sram_addr, sram_oe, sram_we, scc_sel});
    end
    total++;
    if (cfg_mapper !== 3'd0) begin
      bad++;
      $display("FAIL reset_cfg_mapper got=%0d exp=0", cfg_mapper);
    end
    reset_n = 1'b1;
    s = s_rd(16'h0000, E_NONE);
    beat(s, o, x);
    total++;
    if (o !== x) begin bad++; $display("FAIL reset_read got=%h exp=%h", o, x); end
  endtask

  task automatic test_linear();
    stim_t q[$];
    out_t  o, x;
    q.push_back(s_cf(3'd1, 4'd4, 25'h4000));
    q.push_back(s_rd(16'h4123, e_rom(25'h0123)));
    q.push_back(s_rd(16'h8000, E_NONE));
    q.push_back(s_rd(16'h3FFF, E_NONE));
    q.push_back(s_rd(16'h7FFF, e_rom(25'h3FFF)));
    q.push_back(s_mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h4123, 8'h00, E_NONE));
    q.push_back(s_cf(3'd1, 4'd4, 25'h2000));
    q.push_back(s_rd(16'h6005, e_rom(25'h0005)));
    q.push_back(s_cf(3'd0, 4'd0, 25'h0));
    q.push_back(s_rd(16'h0000, E_NONE));
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL linear[%0d] got=%h exp=%h", i, o, x); end
      if (i == 0) begin
        total++;
        if (cfg_mapper !== 3'd1) begin bad++; $display("FAIL linear_cfg_mapper got=%0d exp=1", cfg_mapper); end
      end
    end
  endtask

  task automatic test_konami();
    stim_t q[$];
    out_t  o, x;
    q.push_back(s_cf(3'd3, 4'd0, 25'h40000));
    q.push_back(s_rd(16'h8010, e_rom(25'h04010)));
    q.push_back(s_wr(16'h8000, 8'h05));
    q.push_back(s_rd(16'h8010, e_rom(25'h0A010)));
    q.push_back(s_wr(16'h5000, 8'h07));
    q.push_back(s_rd(16'h5000, e_rom(25'h01000)));
    q.push_back(s_rd(16'h8010, e_rom(25'h0A010)));
    q.push_back(s_wr(16'h6000, 8'h25));
    q.push_back(s_rd(16'h6001, e_rom(25'h0A001)));
    q.push_back(s_mk(1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 8'h09, E_NONE));
    q.push_back(s_rd(16'hA000, e_rom(25'h06000)));
    q.push_back(s_rd(16'hC000, E_NONE));
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL konami[%0d] got=%h exp=%h", i, o, x); end
    end
  endtask

  task automatic test_scc();
    stim_t q[$];
    out_t  o, x;
    q.push_back(s_cf(3'd4, 4'd0, 25'h20000));
    q.push_back(s_rd(16'h9800, e_rom(25'h05800)));
    q.push_back(s_wr(16'h9000, 8'h3F));
    q.push_back(s_rd(16'h9800, e_scc()));
    q.push_back(s_rd(16'h9000, e_rom(25'h1F000)));
    q.push_back(s_wr(16'h9000, 8'h02));
    q.push_back(s_rd(16'h9800, e_rom(25'h05800)));
    q.push_back(s_wr(16'hB000, 8'h01));
    q.push_back(s_rd(16'hB000, e_rom(25'h03000)));
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL scc[%0d] got=%h exp=%h", i, o, x); end
    end
  endtask

  task automatic test_ascii8();
    stim_t q[$];
    out_t  o, x;
    q.push_back(s_cf(3'd5, 4'd0, 25'h20000));
    q.push_back(s_rd(16'hA001, e_rom(25'h00001)));
    q.push_back(s_wr(16'h7800, 8'h23));
    q.push_back(s_rd(16'hA001, e_rom(25'h06001)));
    q.push_back(s_wr(16'h6800, 8'h04));
    q.push_back(s_rd(16'h6002, e_rom(25'h08002)));
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL ascii8[%0d] got=%h exp=%h", i, o, x); end
    end
  endtask

  task automatic test_ascii16();
    stim_t q[$];
    out_t  o, x;
    q.push_back(s_cf(3'd6, 4'd0, 25'h20000));
    q.push_back(s_wr(16'h7000, 8'h0B));
    q.push_back(s_rd(16'h8123, e_rom(25'h0C123)));
    q.push_back(s_rd(16'h4005, e_rom(25'h00005)));
    q.push_back(s_wr(16'h6000, 8'h02));
    q.push_back(s_rd(16'h7FFF, e_rom(25'h0BFFF)));
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL ascii16[%0d] got=%h exp=%h", i, o, x); end
    end
  endtask

  task automatic test_gm2();
    stim_t q[$];
    stim_t s;
    out_t  o, x;
    q.push_back(s_cf(3'd2, 4'd0, 25'h20000));
    q.push_back(s_rd(16'hA000, e_rom(25'h06000)));
    q.push_back(s_wr(16'hA000, 8'h30));
    q.push_back(s_rd(16'hA010, e_sram(13'h1010)));
    q.push_back(s_wr(16'hB004, 8'hAA));
    q.push_back(s_rd(16'hA010, e_sram(13'h1010)));
    q.push_back(s_wr(16'h6000, 8'h10));
    q.push_back(s_rd(16'h6FFF, e_sram(13'h0FFF)));
    s = s_cf(3'd2, 4'd0, 25'h20000);
    s.sl = 1'b1; s.wr = 1'b1; s.a = 16'hB004; s.d = 8'h55;
    q.push_back(s);
    q.push_back(s_rd(16'hA000, e_rom(25'h06000)));
    q.push_back(s_wr(16'hB004, 8'h66));
    q.push_back(s_rd(16'h4005, e_rom(25'h00005)));
    q[4].e = e_swe(13'h1004);
    foreach (q[i]) begin
      beat(q[i], o, x);
      total++;
      if (o !== x) begin bad++; $display("FAIL gm2[%0d] got=%h exp=%h", i, o, x); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    out_t  o, x;
    s = s_rd(16'h4005, e_rom(25'h00005));
    beat(s, o, x);
    total++;
    if (o !== x) begin bad++; $display("FAIL mid_pre got=%h exp=%h", o, x); end
    reset_n = 1'b0;
    #2;
    total++;
    if ({rom_addr, rom_oe, sram_oe, cfg_mapper} !== 29'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=0", {rom_addr, rom_oe, sram_oe, cfg_mapper});
    end
    @(posedge clk);
    #1;
    total++;
    if ({rom_addr, rom_oe} !== 26'd0) begin
      bad++;
      $display("FAIL mid_hold got=%h exp=0", {rom_addr, rom_oe});
    end
    reset_n = 1'b1;
    beat(s_rd(16'h4005, E_NONE), o, x);
    total++;
    if (o !== x) begin bad++; $display("FAIL mid_post got=%h exp=%h", o, x); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; cfg_valid = 1'b0; mapper = 3'd0; offset = 4'd0; rom_size = 25'd0;
    slot_sel = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    test_reset();
    test_linear();
    test_konami();
    test_scc();
    test_ascii8();
    test_ascii16();
    test_gm2();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
